wb_retire_queue: RTL

//  Parametrised writeback stage: MEM->WB entries are buffered in a DEPTH-entry in-order retire

---
 rtl/wb_retire_queue_if.sv | 26 ++
 rtl/wb_retire_queue.sv | 134 +++++++++++++
 2 files changed

// File: rtl/wb_retire_queue_if.sv
// MEM->WB handshake: entry valid, packed entry bus {pc, gr_we, dest, result}, and WB accept.
interface wb_retire_queue_if #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5
);
   localparam int unsigned BUS_W = PC_W + 1 + RADDR_W + DATA_W;

   logic             ms_to_ws_valid;
   logic [BUS_W-1:0] ms_ws_bus;
   logic             ws_allow_in;

   // Memory stage side: offers entries, observes acceptance.
   modport master (
      output ms_to_ws_valid,
      output ms_ws_bus,
      input  ws_allow_in
   );

   // Writeback side: receives entries, grants acceptance.
   modport slave (
      input  ms_to_ws_valid,
      input  ms_ws_bus,
      output ws_allow_in
   );
endinterface

// File: rtl/wb_retire_queue.sv
// Writeback stage with an in-order retire queue. Entries drain to the regfile write port one
// per cycle under rf_wr_ready; pending writes are visible to the forwarding query ports.
module wb_retire_queue #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned NUM_FQ  = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   wb_retire_queue_if.slave              ms_if,
   input  logic                          flush_i,
   input  logic                          rf_wr_ready_i,
   output logic                          rf_we_o,
   output logic [RADDR_W-1:0]            rf_waddr_o,
   output logic [DATA_W-1:0]             rf_wdata_o,
   input  logic [NUM_FQ*RADDR_W-1:0]     fq_raddr_i,
   output logic [NUM_FQ-1:0]             fq_hit_o,
   output logic [NUM_FQ*DATA_W-1:0]      fq_data_o,
   output logic [$clog2(DEPTH+1)-1:0]    ws_count_o,
   output logic [PC_W-1:0]               debug_wb_pc_o,
   output logic [3:0]                    debug_wb_rf_we_o,
   output logic [RADDR_W-1:0]            debug_wb_rf_wnum_o,
   output logic [DATA_W-1:0]             debug_wb_rf_wdata_o
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // Entry storage, split per field; contents are only read while counted as valid.
   logic [PC_W-1:0]    pc_q   [DEPTH];
   logic               we_q   [DEPTH];
   logic [RADDR_W-1:0] dest_q [DEPTH];
   logic [DATA_W-1:0]  data_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic not_empty;
   logic drain;
   logic enq;

   // Reset gates drain so no regfile write escapes during the reset cycle.
   assign not_empty = (count_q != '0);
   assign drain     = not_empty && rf_wr_ready_i && !flush_i && !reset_i;
   assign enq       = ms_if.ms_to_ws_valid && ms_if.ws_allow_in;

   assign ms_if.ws_allow_in = !flush_i && ((count_q != FULL_CNT) || drain);

   assign rf_we_o       = drain && we_q[head_q];
   assign rf_waddr_o    = not_empty ? dest_q[head_q] : '0;
   assign rf_wdata_o    = not_empty ? data_q[head_q] : '0;
   assign debug_wb_pc_o = drain ? pc_q[head_q] : '0;
   assign ws_count_o    = count_q;

   assign debug_wb_rf_we_o    = {4{rf_we_o}};
   assign debug_wb_rf_wnum_o  = rf_we_o ? rf_waddr_o : '0;
   assign debug_wb_rf_wdata_o = rf_we_o ? rf_wdata_o : '0;

   // Next-state for pointers and occupancy; flush empties the queue and overrides everything.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (drain) begin
            head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
         end
         if (enq) begin
            tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
         end
         count_d = count_q + CNT_W'(enq) - CNT_W'(drain);
      end
   end

   // Pointer and occupancy registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Capture an accepted entry at the tail slot.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         data_q[tail_q] <= ms_if.ms_ws_bus[DATA_W-1:0];
         dest_q[tail_q] <= ms_if.ms_ws_bus[DATA_W +: RADDR_W];
         we_q[tail_q]   <= ms_if.ms_ws_bus[DATA_W+RADDR_W];
         pc_q[tail_q]   <= ms_if.ms_ws_bus[DATA_W+RADDR_W+1 +: PC_W];
      end
   end

   logic [RADDR_W-1:0] fq_addr;
   logic [PTR_W:0]     slot_w;
   logic [PTR_W-1:0]   slot;

   // Forwarding search: walk oldest to youngest so the youngest matching write wins.
   // The head is included even when it drains this cycle.
   always_comb begin
      fq_hit_o  = '0;
      fq_data_o = '0;
      fq_addr   = '0;
      slot_w    = '0;
      slot      = '0;
      for (int p = 0; p < int'(NUM_FQ); p++) begin
         fq_addr = fq_raddr_i[p*RADDR_W +: RADDR_W];
         for (int k = 0; k < int'(DEPTH); k++) begin
            slot_w = {1'b0, head_q} + (PTR_W+1)'(k);
            if (slot_w >= (PTR_W+1)'(DEPTH)) begin
               slot_w = slot_w - (PTR_W+1)'(DEPTH);
            end
            slot = slot_w[PTR_W-1:0];
            if ((CNT_W'(k) < count_q) && we_q[slot] && (dest_q[slot] == fq_addr)
                && (fq_addr != '0)) begin
               fq_hit_o[p]                  = 1'b1;
               fq_data_o[p*DATA_W +: DATA_W] = data_q[slot];
            end
         end
      end
   end
endmodule
